// File: rtl/misr_pkg.sv
// misr_pkg
// Shared types, default sizes and the pure MISR next-signature function for
// the misr_sig_analyzer response compactor.
//
// Bit convention: signatures and data words are [0:WIDTH-1]. Bit 0 takes the
// feedback bit f = sig[WIDTH-1]. Tap bit WIDTH-1-i decides whether f is folded
// into position i. This matches the generator's run_L step, so the same tap
// word drives both the pattern generator and this compactor.
package misr_pkg;

    localparam int MISR_WIDTH = 8;
    localparam int MISR_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } misr_state_t;

    // One Galois MISR compress step. The function is sized by MISR_WIDTH, so
    // any instance using it must have WIDTH equal to MISR_WIDTH.
    function automatic logic [0:MISR_WIDTH-1] misr_step(
        input logic [0:MISR_WIDTH-1] sig,
        input logic [MISR_WIDTH-2:0] tap,
        input logic [0:MISR_WIDTH-1] d
    );
        logic                    f;
        logic [0:MISR_WIDTH-1]   nxt;
        f      = sig[MISR_WIDTH-1];
        nxt[0] = f ^ d[0];
        for (int i = 1; i < MISR_WIDTH; i++) begin
            nxt[i] = (tap[MISR_WIDTH-1-i] ? (f ^ sig[i-1]) : sig[i-1]) ^ d[i];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/misr_sig_analyzer_core.sv
// misr_core
// Signature register of the MISR. Load has priority over shift.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears the signature)
//   load         write seed into the signature
//   seed         initial signature value
//   shift        compress d into the signature using tap
//   tap          feedback tap word
//   d            data word to fold in (already masked by the caller)
//   sig          current signature
module misr_core
    import misr_pkg::*;
#(
    parameter int WIDTH = MISR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [0:WIDTH-1] seed,
    input  logic             shift,
    input  logic [WIDTH-2:0] tap,
    input  logic [0:WIDTH-1] d,
    output logic [0:WIDTH-1] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (shift) begin
            sig <= misr_step(sig, tap, d);
        end
    end

endmodule

// File: rtl/misr_sig_analyzer.sv
// misr_sig_analyzer
// Response compactor: folds a stream of response words into a Galois MISR
// signature and compares the final value against a golden signature.
//
// Optional feature: define MISR_XMASK_EN to add the d_mask input; masked bits
// are forced to 0 before compression so X-state bits never reach the MISR.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: latch cfg_* and begin a run (ignored in RUN)
//   cfg_tap           tap word (bit WIDTH-2 selects q[1] .. bit 0 selects q[WIDTH-1])
//   cfg_seed          initial signature
//   cfg_count         number of response words to compress
//   cfg_golden        expected signature
//   d_valid, d_in     response word handshake input
//   d_mask            per-bit X mask (MISR_XMASK_EN only)
//   d_ready           high in RUN
//   busy              high while a run is in progress
//   done              high from run end until the next accepted start
//   signature         current MISR contents
//   pass, fail        done qualified compare result
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting and compressing words until the count runs out
// DONE  | result valid; behaves like IDLE for a new start
module misr_sig_analyzer
    import misr_pkg::*;
#(
    parameter int WIDTH = MISR_WIDTH,
    parameter int CNT_W = MISR_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-2:0] cfg_tap,
    input  logic [0:WIDTH-1] cfg_seed,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [0:WIDTH-1] cfg_golden,
    input  logic             d_valid,
    input  logic [0:WIDTH-1] d_in,
`ifdef MISR_XMASK_EN
    input  logic [0:WIDTH-1] d_mask,
`endif
    output logic             d_ready,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] signature,
    output logic             pass,
    output logic             fail
);

    misr_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-2:0] tap_q;
    logic [0:WIDTH-1] golden_q;
    logic [0:WIDTH-1] d_eff;
    logic             load;
    logic             shift;

`ifdef MISR_XMASK_EN
    assign d_eff = d_in & ~d_mask;
`else
    assign d_eff = d_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load      = 1'b1;
                    // A zero-length run goes straight to DONE with the seed as result.
                    state_nxt = (cfg_count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (d_valid) begin
                    shift = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            tap_q    <= '0;
            golden_q <= '0;
        end else if (load) begin
            cnt      <= cfg_count;
            tap_q    <= cfg_tap;
            golden_q <= cfg_golden;
        end else if (shift && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    misr_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .seed  (cfg_seed),
        .shift (shift),
        .tap   (tap_q),
        .d     (d_eff),
        .sig   (signature)
    );

    assign d_ready = (state == RUN);
    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    // Signature, golden and state are all registers, so these are stable in DONE.
    assign pass    = done && (signature == golden_q);
    assign fail    = done && (signature != golden_q);

endmodule

// File: tb/tb_misr_sig_analyzer.sv
module tb_misr_sig_analyzer;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-2:0]  cfg_tap = '0;
    logic [0:W-1]  cfg_seed = '0;
    logic [CW-1:0] cfg_count = '0;
    logic [0:W-1]  cfg_golden = '0;
    logic          d_valid = 1'b0;
    logic [0:W-1]  d_in = '0;
`ifdef MISR_XMASK_EN
    logic [0:W-1]  d_mask = '0;
`endif
    logic          d_ready, busy, done, pass, fail;
    logic [0:W-1]  signature;

    misr_sig_analyzer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_tap    (cfg_tap),
        .cfg_seed   (cfg_seed),
        .cfg_count  (cfg_count),
        .cfg_golden (cfg_golden),
        .d_valid    (d_valid),
        .d_in       (d_in),
`ifdef MISR_XMASK_EN
        .d_mask     (d_mask),
`endif
        .d_ready    (d_ready),
        .busy       (busy),
        .done       (done),
        .signature  (signature),
        .pass       (pass),
        .fail       (fail)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] TAP = 7'b0100101;

    logic [7:0] wbuf [0:15];
    logic [7:0] mbuf [0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model in literal (MSB-first) order: bit 0 of the word written
    // as a literal is the MSB. The MISR is then a right-shifting Galois LFSR
    // whose feedback polynomial is {1, tap}.
    function automatic logic [7:0] ref_step(input logic [7:0] v, input logic [6:0] tap,
                                            input logic [7:0] d);
        logic [7:0] poly;
        poly = {1'b1, tap};
        return (v >> 1) ^ (v[0] ? poly : 8'h00) ^ d;
    endfunction

    function automatic logic [7:0] ref_run(input logic [7:0] seed, input logic [6:0] tap,
                                           input int count);
        logic [7:0] v;
        v = seed;
        for (int k = 0; k < count; k++) v = ref_step(v, tap, wbuf[k] & ~mbuf[k]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run: start pulse, words from wbuf with 'gap' idle cycles before each.
    task automatic run(input string tag, input logic [7:0] seed, input logic [6:0] tap,
                       input logic [7:0] count, input logic [7:0] golden, input int gap);
        logic [7:0] m;
        m          = seed;
        start      = 1'b1;
        cfg_seed   = seed;
        cfg_tap    = tap;
        cfg_count  = count;
        cfg_golden = golden;
        tick();
        start = 1'b0;
        check({tag, "_seed"}, 32'(signature), 32'(m));
        if (count == 0) begin
            check({tag, "_zc_done"}, 32'(done), 32'd1);
            check({tag, "_zc_ready"}, 32'(d_ready), 32'd0);
        end else begin
            check({tag, "_busy0"}, 32'(busy), 32'd1);
        end
        for (int k = 0; k < int'(count); k++) begin
            for (int g = 0; g < gap; g++) begin
                d_valid = 1'b0;
                d_in    = 8'hFF;
                tick();
                check({tag, "_gap_busy"}, 32'(busy), 32'd1);
                check({tag, "_gap_hold"}, 32'(signature), 32'(m));
            end
            d_valid = 1'b1;
            d_in    = wbuf[k];
`ifdef MISR_XMASK_EN
            d_mask  = mbuf[k];
`endif
            #1;
            check({tag, "_ready"}, 32'(d_ready), 32'd1);
            tick();
            d_valid = 1'b0;
            m = ref_step(m, tap, wbuf[k] & ~mbuf[k]);
            check({tag, "_sig"}, 32'(signature), 32'(m));
            if (k < int'(count) - 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            else begin
                check({tag, "_done"}, 32'(done), 32'd1);
                check({tag, "_busy_end"}, 32'(busy), 32'd0);
            end
        end
        check({tag, "_pass"}, 32'(pass), 32'(m == golden));
        check({tag, "_fail"}, 32'(fail), 32'(m != golden));
    endtask

    typedef struct {
        logic [7:0] seed;
        logic [7:0] count;
        logic [7:0] golden;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] exp_sig;
        logic       exp_pass;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp;
        logic [7:0] gold;
        int         cnt_r;
        int         gap_r;
        logic [6:0] tap_r;
        logic [7:0] seed_r;

        vecs[0] = '{8'h00, 8'd1, 8'h80, 8'h80, 8'h00, 8'h80, 1'b1}; // zero seed
        vecs[1] = '{8'h0F, 8'd1, 8'hA2, 8'h00, 8'h00, 8'hA2, 1'b1}; // generator step
        vecs[2] = '{8'h5A, 8'd0, 8'h5A, 8'h00, 8'h00, 8'h5A, 1'b1}; // zero count
        vecs[3] = '{8'h5A, 8'd0, 8'h00, 8'h00, 8'h00, 8'h5A, 1'b0};
        vecs[4] = '{8'h0F, 8'd1, 8'h00, 8'h00, 8'h00, 8'hA2, 1'b0};
        vecs[5] = '{8'h01, 8'd2, 8'hF7, 8'h00, 8'h00, 8'hF7, 1'b1};
        for (int k = 0; k < 16; k++) begin
            wbuf[k] = '0;
            mbuf[k] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sig", 32'(signature), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(d_ready), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        rst_n = 1'b1;

        // d_valid in IDLE is ignored
        d_valid = 1'b1;
        d_in    = 8'hFF;
        #1;
        check("idle_ready", 32'(d_ready), 32'd0);
        tick();
        tick();
        d_valid = 1'b0;
        check("idle_sig", 32'(signature), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            wbuf[0] = vecs[v].w0;
            wbuf[1] = vecs[v].w1;
            run($sformatf("vec%0d", v), vecs[v].seed, TAP, vecs[v].count, vecs[v].golden, 0);
            check($sformatf("vec%0d_tbl_sig", v), 32'(signature), 32'(vecs[v].exp_sig));
            check($sformatf("vec%0d_tbl_pass", v), 32'(pass), 32'(vecs[v].exp_pass));
            check($sformatf("vec%0d_tbl_fail", v), 32'(fail), 32'(!vecs[v].exp_pass));
        end

        // d_valid in DONE is ignored
        exp     = signature;
        d_valid = 1'b1;
        d_in    = 8'h3C;
        #1;
        check("done_ready", 32'(d_ready), 32'd0);
        tick();
        tick();
        d_valid = 1'b0;
        check("done_sig_hold", 32'(signature), 32'hF7);
        check("done_hold", 32'(done), 32'd1);

        // Backpressure: same data back-to-back and with 2-cycle gaps
        wbuf[0] = 8'h3C; wbuf[1] = 8'hA7; wbuf[2] = 8'h19;
        exp = ref_run(8'h96, TAP, 3);
        run("b2b", 8'h96, TAP, 8'd3, exp, 0);
        check("b2b_final", 32'(signature), 32'(exp));
        run("gaps", 8'h96, TAP, 8'd3, exp, 2);
        check("gaps_final", 32'(signature), 32'(exp));
        check("gaps_pass", 32'(pass), 32'd1);

        // Second start mid-RUN is ignored
        wbuf[0] = 8'h55; wbuf[1] = 8'h12; wbuf[2] = 8'hE0;
        exp        = ref_run(8'h11, TAP, 3);
        start      = 1'b1;
        cfg_seed   = 8'h11;
        cfg_tap    = TAP;
        cfg_count  = 8'd3;
        cfg_golden = exp;
        tick();
        start   = 1'b0;
        d_valid = 1'b1;
        d_in    = wbuf[0];
        tick();
        d_valid    = 1'b0;
        start      = 1'b1;
        cfg_seed   = 8'hFF;
        cfg_tap    = 7'h7F;
        cfg_count  = 8'd1;
        cfg_golden = 8'h00;
        tick();
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_sig", 32'(signature), 32'(ref_step(8'h11, TAP, wbuf[0])));
        for (int k = 1; k < 3; k++) begin
            d_valid = 1'b1;
            d_in    = wbuf[k];
            tick();
        end
        d_valid = 1'b0;
        check("restart_final", 32'(signature), 32'(exp));
        check("restart_done", 32'(done), 32'd1);
        check("restart_pass", 32'(pass), 32'd1);

        // Reset mid-RUN aborts
        start      = 1'b1;
        cfg_seed   = 8'h3C;
        cfg_count  = 8'd3;
        cfg_golden = 8'h00;
        tick();
        start   = 1'b0;
        d_valid = 1'b1;
        d_in    = 8'h81;
        tick();
        d_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_sig", 32'(signature), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);

`ifdef MISR_XMASK_EN
        wbuf[0] = 8'hFF;
        mbuf[0] = 8'h0F;
        run("mask", 8'h00, TAP, 8'd1, 8'hF0, 0);
        check("mask_sig", 32'(signature), 32'hF0);
        mbuf[0] = 8'h00;
`endif

        // Randomized runs against the reference model
        for (int r = 0; r < 25; r++) begin
            tap_r  = 7'($urandom);
            seed_r = 8'($urandom);
            cnt_r  = int'($urandom_range(1, 6));
            gap_r  = int'($urandom_range(0, 2));
            for (int k = 0; k < cnt_r; k++) begin
                wbuf[k] = 8'($urandom);
`ifdef MISR_XMASK_EN
                mbuf[k] = 8'($urandom);
`endif
            end
            exp  = ref_run(seed_r, tap_r, cnt_r);
            gold = ($urandom_range(0, 1) == 1) ? exp : (exp ^ 8'($urandom_range(1, 255)));
            run($sformatf("rnd%0d", r), seed_r, tap_r, 8'(cnt_r), gold, gap_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
